// File: rtl/vga_timing_gen_pkg.sv
// VGA 640x480@60 timing constants and coordinate type shared by the
// timing generator and displaycontrol.
package vga_timing_gen_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_HS_START  = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_HS_END    = VGA_HS_START + VGA_H_SYNC;

    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int unsigned VGA_VS_START  = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int unsigned VGA_VS_END    = VGA_VS_START + VGA_V_SYNC;

    localparam int unsigned VGA_CLK_DIV   = 4;

    localparam int unsigned FRAME_CNT_W   = 16;

    // Half-open window test [lo, hi) on unsigned coordinates.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel enable, coordinates, syncs and frame strobe.
// Optional macro: VGA_FRAME_CNT_EN adds the frame_cnt signal.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic   p_tick;
    coord_t x;
    coord_t y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;
`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, frame_tick
`ifdef VGA_FRAME_CNT_EN
        , frame_cnt
`endif
    );

    modport slave (
        input p_tick, x, y, video_on, hsync, vsync, frame_tick
`ifdef VGA_FRAME_CNT_EN
        , frame_cnt
`endif
    );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-enable divider: p_tick is high for one clk every CLK_DIV clks.
module vga_timing_gen_pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_100MHz,
    input  logic rst,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Wrapping divider count.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel enable, h/v counters, sync/blank decode and
// a per-frame object-update strobe.
// Optional macro: VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam coord_t X_LAST     = COORD_W'(H_TOTAL - 1);
    localparam coord_t Y_LAST     = COORD_W'(V_TOTAL - 1);
    localparam coord_t FT_LINE    = COORD_W'(V_DISPLAY + 1);

    logic   p_tick;
    coord_t x_q,        x_d;
    coord_t y_q,        y_d;
    logic   hsync_q,    hsync_d;
    logic   vsync_q,    vsync_d;
    logic   video_on_q, video_on_d;
    logic   frame_tick_q, frame_tick_d;

    vga_timing_gen_pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .p_tick     (p_tick)
    );

    // Advance counters on p_tick; decode syncs/blank from the next-state
    // coordinates so they change in the same clk as x/y.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        video_on_d   = video_on_q;
        frame_tick_d = 1'b0;
        if (p_tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? coord_t'('0) : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
            hsync_d      = ~in_window(x_d, COORD_W'(HS_START), COORD_W'(HS_END));
            vsync_d      = ~in_window(y_d, COORD_W'(VS_START), COORD_W'(VS_END));
            video_on_d   = (x_d < COORD_W'(H_DISPLAY)) && (y_d < COORD_W'(V_DISPLAY));
            frame_tick_d = (x_d == '0) && (y_d == FT_LINE);
        end
    end

    // Timing state registers; frame_tick is rewritten every clk so it
    // lasts a single clk rather than a pixel period.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Count frames in the same clk that frame_tick rises.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.p_tick     = p_tick;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.video_on   = video_on_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.frame_tick = frame_tick_q;

endmodule
